// File: rtl/rf_wb_fwd_if.sv
// Bundle between the writeback/bypass unit and its neighbours: EX results,
// memory read data, decode read requests, raw register-file reads and the write port.
interface rf_wb_fwd_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic [AW-1:0] ex_dst_addr;
  logic          ex_we;
  logic          ex_is_ld;
  logic [DW-1:0] ex_result;
  logic [DW-1:0] mem_rd_data;
  logic          hlt;
  logic [AW-1:0] id_p0_addr;
  logic [AW-1:0] id_p1_addr;
  logic          id_re0;
  logic          id_re1;
  logic [DW-1:0] rf_p0;
  logic [DW-1:0] rf_p1;
  logic [AW-1:0] rf_dst_addr;
  logic [DW-1:0] rf_dst;
  logic          rf_we;
  logic [DW-1:0] id_p0;
  logic [DW-1:0] id_p1;
  logic          stall;
  logic          halted;

  modport master (
    output ex_dst_addr, ex_we, ex_is_ld, ex_result, mem_rd_data, hlt,
    output id_p0_addr, id_p1_addr, id_re0, id_re1, rf_p0, rf_p1,
    input  rf_dst_addr, rf_dst, rf_we, id_p0, id_p1, stall, halted
  );

  modport slave (
    input  ex_dst_addr, ex_we, ex_is_ld, ex_result, mem_rd_data, hlt,
    input  id_p0_addr, id_p1_addr, id_re0, id_re1, rf_p0, rf_p1,
    output rf_dst_addr, rf_dst, rf_we, id_p0, id_p1, stall, halted
  );
endinterface

// File: rtl/rf_wb_fwd.sv
// Writeback and operand-bypass unit: EX/MEM and MEM/WB pipeline registers,
// register-file write port, two-port forwarding, load-use stall and halt drain.
module rf_wb_fwd #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input logic       clk,
  input logic       rst,
  rf_wb_fwd_if.slave bus
);

  logic [AW-1:0] exm_addr_q, exm_addr_d;
  logic          exm_we_q, exm_we_d;
  logic          exm_ld_q, exm_ld_d;
  logic [DW-1:0] exm_res_q, exm_res_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic          wb_we_q, wb_we_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          seen_q, seen_d;
  logic          halted_q, halted_d;

  logic          ex_fwd_v_s;
  logic [DW-1:0] exm_fwd_data_s;
  logic          stall_s;
  logic [DW-1:0] id_p0_s, id_p1_s;

  // Priority bypass for one read port; R0 and disabled ports always see the raw read.
  function automatic logic [DW-1:0] fwd_sel(
    input logic          re,
    input logic [AW-1:0] addr,
    input logic [DW-1:0] raw,
    input logic          ex_v,
    input logic [AW-1:0] ex_a,
    input logic [DW-1:0] ex_d,
    input logic          mem_v,
    input logic [AW-1:0] mem_a,
    input logic [DW-1:0] mem_d
  );
    logic [DW-1:0] r;
    r = raw;
    if (!re || (addr == {AW{1'b0}})) begin
      r = raw;
    end else if (ex_v && (ex_a == addr)) begin
      r = ex_d;
    end else if (mem_v && (mem_a == addr)) begin
      r = mem_d;
    end else begin
      r = raw;
    end
    return r;
  endfunction

  // Next state of both pipeline registers; halt injects a bubble into EX/MEM.
  always_comb begin
    if (bus.hlt) begin
      exm_addr_d = {AW{1'b0}};
      exm_we_d   = 1'b0;
      exm_ld_d   = 1'b0;
      exm_res_d  = {DW{1'b0}};
    end else begin
      exm_addr_d = bus.ex_dst_addr;
      exm_we_d   = bus.ex_we;
      exm_ld_d   = bus.ex_is_ld;
      exm_res_d  = bus.ex_result;
    end
    wb_addr_d = exm_addr_q;
    wb_we_d   = exm_we_q & (exm_addr_q != {AW{1'b0}});
    if (exm_ld_q) begin
      wb_data_d = bus.mem_rd_data;
    end else begin
      wb_data_d = exm_res_q;
    end
  end

  // Drain counter: two cycles after hlt is first seen both stages hold bubbles.
  always_comb begin
    seen_d = bus.hlt;
    if (!bus.hlt) begin
      cnt_d = 2'd0;
    end else if (!seen_q) begin
      cnt_d = 2'd2;
    end else if (cnt_q != 2'd0) begin
      cnt_d = cnt_q - 2'd1;
    end else begin
      cnt_d = 2'd0;
    end
    halted_d = bus.hlt & seen_q & (cnt_q <= 2'd1);
  end

  // Forwarding and load-use detection; everything is neutral while in reset.
  always_comb begin
    ex_fwd_v_s = ~rst & bus.ex_we & ~bus.ex_is_ld;
    if (exm_ld_q) begin
      exm_fwd_data_s = bus.mem_rd_data;
    end else begin
      exm_fwd_data_s = exm_res_q;
    end
    stall_s = ~rst & bus.ex_we & bus.ex_is_ld & (bus.ex_dst_addr != {AW{1'b0}}) &
              ((bus.id_re0 & (bus.id_p0_addr == bus.ex_dst_addr)) |
               (bus.id_re1 & (bus.id_p1_addr == bus.ex_dst_addr)));
    id_p0_s = fwd_sel(bus.id_re0, bus.id_p0_addr, bus.rf_p0, ex_fwd_v_s, bus.ex_dst_addr,
                      bus.ex_result, exm_we_q, exm_addr_q, exm_fwd_data_s);
    id_p1_s = fwd_sel(bus.id_re1, bus.id_p1_addr, bus.rf_p1, ex_fwd_v_s, bus.ex_dst_addr,
                      bus.ex_result, exm_we_q, exm_addr_q, exm_fwd_data_s);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exm_addr_q <= {AW{1'b0}};
      exm_we_q   <= 1'b0;
      exm_ld_q   <= 1'b0;
      exm_res_q  <= {DW{1'b0}};
      wb_addr_q  <= {AW{1'b0}};
      wb_we_q    <= 1'b0;
      wb_data_q  <= {DW{1'b0}};
      cnt_q      <= 2'd0;
      seen_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      exm_addr_q <= exm_addr_d;
      exm_we_q   <= exm_we_d;
      exm_ld_q   <= exm_ld_d;
      exm_res_q  <= exm_res_d;
      wb_addr_q  <= wb_addr_d;
      wb_we_q    <= wb_we_d;
      wb_data_q  <= wb_data_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.rf_dst_addr = wb_addr_q;
  assign bus.rf_dst      = wb_data_q;
  assign bus.rf_we       = wb_we_q;
  assign bus.halted      = halted_q;
  assign bus.stall       = stall_s;
  assign bus.id_p0       = id_p0_s;
  assign bus.id_p1       = id_p1_s;

endmodule

// File: tb/tb_rf_wb_fwd.sv
// Directed and random checks of rf_wb_fwd against an in-flight-queue reference model.
module tb_rf_wb_fwd;

  typedef struct packed {
    logic        we;
    logic [3:0]  a;
    logic        ld;
    logic [15:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nchk = 0;
  int   nerr = 0;
  ent_t em_m, wb_m;
  int   hrun;

  always #5 clk = ~clk;

  rf_wb_fwd_if #(.DW(16), .AW(4)) bus ();
  rf_wb_fwd #(.DW(16), .AW(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_op(input logic re, input logic [3:0] a, input logic [15:0] raw);
    if (rst || !re || a == 4'd0) return raw;
    if (bus.ex_we && !bus.ex_is_ld && bus.ex_dst_addr == a) return bus.ex_result;
    if (em_m.we && em_m.a == a) return em_m.ld ? bus.mem_rd_data : em_m.d;
    return raw;
  endfunction

  function automatic logic ld_hit(input logic re, input logic [3:0] a);
    return bus.ex_we && bus.ex_is_ld && bus.ex_dst_addr != 4'd0 && re && a == bus.ex_dst_addr;
  endfunction

  task automatic model_reset();
    em_m = '0;
    wb_m = '0;
    hrun = 0;
  endtask

  task automatic check_all();
    logic exp_we;
    exp_we = !rst && wb_m.we && wb_m.a != 4'd0;
    chk("rf_we", {31'd0, bus.rf_we}, {31'd0, exp_we});
    if (rst) begin
      chk("rst_addr", {28'd0, bus.rf_dst_addr}, 32'd0);
      chk("rst_dst", {16'd0, bus.rf_dst}, 32'd0);
    end else if (exp_we) begin
      chk("rf_dst_addr", {28'd0, bus.rf_dst_addr}, {28'd0, wb_m.a});
      chk("rf_dst", {16'd0, bus.rf_dst}, {16'd0, wb_m.d});
    end
    chk("stall", {31'd0, bus.stall},
        {31'd0, !rst && (ld_hit(bus.id_re0, bus.id_p0_addr) || ld_hit(bus.id_re1, bus.id_p1_addr))});
    chk("halted", {31'd0, bus.halted}, {31'd0, !rst && hrun >= 3});
    if (rst || !ld_hit(bus.id_re0, bus.id_p0_addr))
      chk("id_p0", {16'd0, bus.id_p0}, {16'd0, exp_op(bus.id_re0, bus.id_p0_addr, bus.rf_p0)});
    if (rst || !ld_hit(bus.id_re1, bus.id_p1_addr))
      chk("id_p1", {16'd0, bus.id_p1}, {16'd0, exp_op(bus.id_re1, bus.id_p1_addr, bus.rf_p1)});
  endtask

  // Advance one clock: entries move one stage older, loads resolve leaving MEM.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      wb_m.we = em_m.we;
      wb_m.a  = em_m.a;
      wb_m.ld = 1'b0;
      wb_m.d  = em_m.ld ? bus.mem_rd_data : em_m.d;
      if (bus.hlt) em_m = '0;
      else em_m = '{we: bus.ex_we, a: bus.ex_dst_addr, ld: bus.ex_is_ld, d: bus.ex_result};
      hrun = bus.hlt ? hrun + 1 : 0;
    end
    #1;
  endtask

  task automatic ex(input logic we, input logic [3:0] a, input logic ld, input logic [15:0] d);
    bus.ex_we = we;
    bus.ex_dst_addr = a;
    bus.ex_is_ld = ld;
    bus.ex_result = d;
  endtask

  task automatic rd(input logic re0, input logic [3:0] a0, input logic re1, input logic [3:0] a1);
    bus.id_re0 = re0;
    bus.id_p0_addr = a0;
    bus.id_re1 = re1;
    bus.id_p1_addr = a1;
  endtask

  initial begin
    ex(1'b0, 4'd0, 1'b0, 16'h0);
    rd(1'b0, 4'd0, 1'b0, 4'd0);
    bus.mem_rd_data = 16'h0;
    bus.hlt = 1'b0;
    bus.rf_p0 = 16'hA0A0;
    bus.rf_p1 = 16'hB1B1;
    model_reset();

    // Reset state
    rst = 1'b1;
    ex(1'b1, 4'd3, 1'b0, 16'h4444);
    rd(1'b1, 4'd3, 1'b1, 4'd3);
    #2;
    check_all();
    chk("rst_id_p0", {16'd0, bus.id_p0}, 32'h0000A0A0);
    tick();
    tick();
    rst = 1'b0;
    ex(1'b0, 4'd0, 1'b0, 16'h0);
    rd(1'b0, 4'd0, 1'b0, 4'd0);
    tick();

    // Back-to-back ALU
    ex(1'b1, 4'd3, 1'b0, 16'h1234);
    rd(1'b1, 4'd3, 1'b0, 4'd0);
    #1; check_all(); chk("b2b_ex", {16'd0, bus.id_p0}, 32'h1234);
    tick();
    ex(1'b0, 4'd0, 1'b0, 16'h0);
    #1; check_all(); chk("b2b_exm", {16'd0, bus.id_p0}, 32'h1234);
    tick();
    rd(1'b0, 4'd0, 1'b0, 4'd0);
    #1; check_all();
    chk("b2b_we", {31'd0, bus.rf_we}, 32'd1);
    chk("b2b_addr", {28'd0, bus.rf_dst_addr}, 32'd3);
    chk("b2b_dst", {16'd0, bus.rf_dst}, 32'h1234);
    tick();

    // Load-use
    ex(1'b1, 4'd5, 1'b1, 16'h0040);
    rd(1'b0, 4'd0, 1'b1, 4'd5);
    #1; check_all(); chk("lu_stall", {31'd0, bus.stall}, 32'd1);
    tick();
    ex(1'b0, 4'd0, 1'b0, 16'h0);
    bus.mem_rd_data = 16'hBEEF;
    #1; check_all();
    chk("lu_fwd", {16'd0, bus.id_p1}, 32'hBEEF);
    chk("lu_nostall", {31'd0, bus.stall}, 32'd0);
    tick();
    rd(1'b0, 4'd0, 1'b0, 4'd0);
    #1; check_all(); chk("lu_wb", {16'd0, bus.rf_dst}, 32'hBEEF);
    tick();

    // Priority and read-enable off
    ex(1'b1, 4'd2, 1'b0, 16'h0002);
    #1; check_all();
    tick();
    ex(1'b1, 4'd2, 1'b0, 16'h0001);
    rd(1'b1, 4'd2, 1'b0, 4'd0);
    #1; check_all(); chk("prio", {16'd0, bus.id_p0}, 32'h0001);
    bus.id_re0 = 1'b0;
    bus.rf_p0 = 16'h5A5A;
    #1; check_all(); chk("re_off", {16'd0, bus.id_p0}, 32'h5A5A);
    tick();

    // R0 is never forwarded or written
    ex(1'b1, 4'd0, 1'b0, 16'hFFFF);
    rd(1'b1, 4'd0, 1'b0, 4'd0);
    bus.rf_p0 = 16'h1111;
    #1; check_all(); chk("r0_fwd", {16'd0, bus.id_p0}, 32'h1111);
    tick();
    ex(1'b0, 4'd0, 1'b0, 16'h0);
    #1; check_all();
    tick();
    #1; check_all(); chk("r0_we", {31'd0, bus.rf_we}, 32'd0);
    tick();

    // Halt drain with two writes in flight
    ex(1'b1, 4'd7, 1'b0, 16'h7777);
    tick();
    ex(1'b1, 4'd8, 1'b0, 16'h8888);
    tick();
    ex(1'b1, 4'd9, 1'b0, 16'h9999);
    bus.hlt = 1'b1;
    #1; check_all(); chk("h0_dst", {16'd0, bus.rf_dst}, 32'h7777);
    tick();
    #1; check_all(); chk("h1_dst", {16'd0, bus.rf_dst}, 32'h8888);
    chk("h1_halted", {31'd0, bus.halted}, 32'd0);
    tick();
    #1; check_all(); chk("h2_we", {31'd0, bus.rf_we}, 32'd0);
    tick();
    #1; check_all(); chk("h3_halted", {31'd0, bus.halted}, 32'd1);
    tick();
    #1; check_all();
    bus.hlt = 1'b0;
    ex(1'b0, 4'd0, 1'b0, 16'h0);
    tick();
    #1; check_all(); chk("unhalt", {31'd0, bus.halted}, 32'd0);
    tick();

    // Async reset with MEM/WB valid
    ex(1'b1, 4'd9, 1'b0, 16'h9999);
    tick();
    ex(1'b0, 4'd0, 1'b0, 16'h0);
    tick();
    #1; check_all(); chk("pre_rst_we", {31'd0, bus.rf_we}, 32'd1);
    #1;
    rst = 1'b1;
    model_reset();
    #1; check_all(); chk("async_we", {31'd0, bus.rf_we}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      ex($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
         16'($urandom));
      rd($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)),
         $urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)));
      bus.mem_rd_data = 16'($urandom);
      bus.rf_p0 = 16'($urandom);
      bus.rf_p1 = 16'($urandom);
      if (bus.hlt) bus.hlt = $urandom_range(0, 9) != 0;
      else bus.hlt = $urandom_range(0, 19) == 0;
      rst = $urandom_range(0, 99) == 0;
      if (rst) model_reset();
      #1; check_all();
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
